ff_inv4_seq: RTL and testbench
==============================

# ff_inv4_seq

Multi-cycle GF(2^4) arithmetic unit that shares a single `FFMul_K4_Q2` multiplier instance (field polynomial x^4+x+1) between two operations.
- Plain multiply, a*b.
- Multiplicative inverse, a^-1, computed as a^14 by a fixed five-step square/multiply schedule.

It is the inversion engine for the composite-field SubBytes datapath. It accepts one operation at a time through a valid/ready handshake and presents the result through a held valid/ready output.

## Interface
- No parameters; field width fixed at 4 bits.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operation request
- `in_ready`  out  1  block can accept a request this cycle
- `in_op`  in  1  0 = multiply (a*b), 1 = inverse (a^-1; b ignored)
- `in_a`  in  4  operand a
- `in_b`  in  4  operand b
- `out_valid`  out  1  result valid, held until consumed
- `out_ready`  in  1  consumer accepts result
- `out_data`  out  4  result
- `busy`  out  1  FSM not IDLE

## Operation
- Exactly one `FFMul_K4_Q2` instance. Its operands are muxed from internal registers; its product is always registered, never passed combinationally to `out_data`.
- Internal registers: `x`, `r2`, `r4`, `acc` (all 4 bit), `op`, `step` (3 bit), `state`.
- FSM states: IDLE, RUN.
- **IDLE:** `in_ready = !out_valid | out_ready`. On `in_valid & in_ready`:
  - capture a into `x` and b into `acc`; capture `op`;
  - `step <= 0`; go to RUN.
- **RUN, op = 0:** step 0 computes `x*acc` and loads it into `out_data`. Set `out_valid`, go to IDLE.
- **RUN, op = 1:** one multiply per cycle.
  - step 0: `x*x` -> `r2`
  - step 1: `r2*r2` -> `r4`
  - step 2: `r2*r4` -> `acc` (x^6)
  - step 3: `r4*r4` -> `r2` (x^8)
  - step 4: `acc*r2` -> `out_data` (x^14); set `out_valid`, go to IDLE.
- `step` increments every RUN cycle.
- Inverse of 0 is defined as 0. This falls out of the schedule; no special case.
- **Output handshake:**
  - `out_valid` and `out_data` hold until `out_valid & out_ready`; then `out_valid` clears at that edge.
  - `out_data` keeps its last value after being consumed.
  - Completion and consumption never coincide, because a new request is only accepted when the output register is free or being freed.
- `in_op`, `in_a` and `in_b` are sampled only at the accept edge. Changes during RUN have no effect.
- `in_valid` during RUN is ignored (`in_ready = 0`). No queueing; the requester holds its request.

## Timing
- Reset values: `state` = IDLE, `out_valid` = 0, `out_data` = 0, `busy` = 0, all internal registers 0.
  - After reset `in_ready` = 1.
- Reset asserted mid-RUN aborts the operation immediately. No result is produced, and the block is ready again the cycle after reset deasserts.
- Accept at edge E:
  - multiply: `out_valid` high after edge E+1 (latency 2 edges);
  - inverse: `out_valid` high after edge E+5 (latency 6 edges).
- `busy` = 1 from E+0 until the completing edge (E+1 or E+5), inclusive of the RUN cycles.
- Back-to-back: if `out_ready` is held high, a new request is accepted in the first cycle after completion.
  - Peak throughput: 1 multiply per 2 cycles, 1 inverse per 6 cycles.
- Output stall: while `out_valid = 1` and `out_ready = 0`, `in_ready` = 0. The block stays in IDLE with output held indefinitely.
- Simultaneous events in IDLE: `out_valid & out_ready` together with `in_valid`.
  - Both handshakes complete on the same edge: output cleared, new operation started.

## Test plan
- **Reset state:** assert `rst` asynchronously mid-cycle -> `out_valid` = 0, `out_data` = 0, `busy` = 0, `in_ready` = 1 without waiting for a clock edge.
- **Multiply:** op=0 for (4,3), (2,2), (5,8), (15,15) with `out_ready` = 1 -> results 12, 4, 14, 10, each with `out_valid` rising 2 edges after accept.
- **Inverse:** op=1 for a = 2, 3, 15, 1, 0 -> results 9, 14, 8, 1, 0, each 6 edges after accept.
  - Exhaustive check over a = 1..15: a * result = 1.
- **Backpressure:** `out_ready` = 0 for 10 cycles after completion -> `out_data` and `out_valid` stable and `in_ready` = 0 throughout.
  - Raise `out_ready` while `in_valid` is high -> output consumed and new op accepted on the same edge.
- **Input ignored during RUN:** change `in_a` and toggle `in_valid` during an inverse of 3 -> result still 14, and no extra operation is started.
- **Reset mid-operation:** pulse `rst` at step 2 of an inverse -> no `out_valid` is produced.
  - Next inverse of 15 after reset returns 8 with normal latency.

Source files
------------

// File: rtl/ff_inv4_seq.sv
// GF(2^4) multiply / inverse unit (x^4+x+1) built around one shared multiplier.
// The inverse is a^14, evaluated as x^2, x^4, x^6, x^8, x^14 over five cycles.

module FFMul_K4_Q2 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] p_o
);

    logic [6:0] t;

    // Carry-less product followed by reduction of bits 6..4 by x^4 = x + 1.
    always_comb begin
        t = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (b_i[i]) t = t ^ (7'(a_i) << i);
        end
        for (int unsigned k = 6; k >= 4; k--) begin
            if (t[k]) t = t ^ (7'b0010011 << (k - 4));
        end
        p_o = t[3:0];
    end

endmodule

module ff_inv4_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_op,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       busy
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_q;
    logic [3:0] x_q, r2_q, r4_q, acc_q;
    logic       op_q;
    logic [2:0] step_q;
    logic       out_valid_q;
    logic [3:0] out_data_q;

    logic [3:0] mul_a, mul_b, prod_d;

    always_comb begin
        mul_a = x_q;
        mul_b = acc_q;
        if (op_q) begin
            case (step_q)
                3'd0:    begin mul_a = x_q;   mul_b = x_q;  end
                3'd1:    begin mul_a = r2_q;  mul_b = r2_q; end
                3'd2:    begin mul_a = r2_q;  mul_b = r4_q; end
                3'd3:    begin mul_a = r4_q;  mul_b = r4_q; end
                default: begin mul_a = acc_q; mul_b = r2_q; end
            endcase
        end
    end

    FFMul_K4_Q2 u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (prod_d)
    );

    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            r2_q        <= '0;
            r4_q        <= '0;
            acc_q       <= '0;
            op_q        <= 1'b0;
            step_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            // Consumption precedes completion; the two never fall on the same edge.
            if (out_valid_q && out_ready) out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        x_q     <= in_a;
                        acc_q   <= in_b;
                        op_q    <= in_op;
                        step_q  <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    step_q <= step_q + 3'd1;
                    if (!op_q) begin
                        out_data_q  <= prod_d;
                        out_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        case (step_q)
                            3'd0:    r2_q  <= prod_d;
                            3'd1:    r4_q  <= prod_d;
                            3'd2:    acc_q <= prod_d;
                            3'd3:    r2_q  <= prod_d;
                            default: begin
                                out_data_q  <= prod_d;
                                out_valid_q <= 1'b1;
                                state_q     <= IDLE;
                            end
                        endcase
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ff_inv4_seq.sv
// Scoreboard bench for ff_inv4_seq: accepts are observed and the expected result
// (from a log/antilog model of GF(16)) is queued; a monitor checks each output.

module tb_ff_inv4_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_op;
    logic [3:0] in_a, in_b;
    logic       out_valid, out_ready, busy;
    logic [3:0] out_data;

    always #5 clk = ~clk;

    ff_inv4_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    typedef struct {
        bit op;
        int a;
        int expv;
        int acc_cyc;
    } exp_t;

    exp_t q[$];
    int   ncmp = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   pend_exp = -1;
    bit   rand_rdy = 1'b0;
    bit   prev_ov = 1'b0;
    int   gexp[15];
    int   glog[16];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int mdl_mul(int a, int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] + glog[b]) % 15];
    endfunction

    function automatic int mdl_inv(int a);
        if (a == 0) return 0;
        return gexp[(15 - glog[a]) % 15];
    endfunction

    task automatic chk(input string name, input int act, input int req);
        ncmp++;
        if (act != req) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Input monitor: an accept happens on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && in_valid && in_ready) begin
            e.op      = in_op;
            e.a       = int'(in_a);
            e.expv    = (pend_exp >= 0) ? pend_exp
                      : (in_op ? mdl_inv(int'(in_a)) : mdl_mul(int'(in_a), int'(in_b)));
            e.acc_cyc = cyc + 1;
            q.push_back(e);
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = q[0];
                    chk(e.op ? "inv_data" : "mul_data", int'(out_data), e.expv);
                    chk(e.op ? "inv_latency" : "mul_latency", cyc - e.acc_cyc, e.op ? 5 : 1);
                    if (e.op && e.a != 0) chk("inv_product_is_one", mdl_mul(e.a, int'(out_data)), 1);
                end
            end
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            prev_ov = out_valid;
        end
    end

    task automatic issue(input bit op, input int a, input int b, input int expv);
        bit acc;
        int n;
        pend_exp = expv;
        in_op    = op;
        in_a     = 4'(a);
        in_b     = 4'(b);
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
            n++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        pend_exp = -1;
    endtask

    task automatic wait_valid(input int limit);
        int n;
        n = 0;
        while (!out_valid && n < limit) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    initial begin
        int e;
        int m_a [4] = '{4, 2, 5, 15};
        int m_b [4] = '{3, 2, 8, 15};
        int m_r [4] = '{12, 4, 14, 10};
        int i_a [5] = '{2, 3, 15, 1, 0};
        int i_r [5] = '{9, 14, 8, 1, 0};
        int held;

        e = 1;
        for (int i = 0; i < 15; i++) begin
            gexp[i] = e;
            glog[e] = i;
            e = e << 1;
            if ((e & 16) != 0) e = e ^ 19;
        end
        glog[0] = 0;

        rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        #3;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        #9 rst = 1'b0;
        @(posedge clk); #2;

        for (int i = 0; i < 4; i++) issue(1'b0, m_a[i], m_b[i], m_r[i]);
        for (int i = 0; i < 5; i++) issue(1'b1, i_a[i], $urandom_range(0, 15), i_r[i]);
        for (int a = 1; a < 16; a++) issue(1'b1, a, 0, -1);
        repeat (8) @(posedge clk);
        #2;

        // Backpressure, then simultaneous consume + accept.
        out_ready = 1'b0;
        issue(1'b0, 7, 9, -1);
        wait_valid(20);
        held = mdl_mul(7, 9);
        pend_exp = 9; in_op = 1'b1; in_a = 4'd2; in_b = 4'd0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_out_data", int'(out_data), held);
            chk("stall_in_ready", int'(in_ready), 0);
            @(posedge clk); #2;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("simul_in_ready", int'(in_ready), 1);
        @(posedge clk); #2;
        in_valid = 1'b0; pend_exp = -1;
        chk("simul_out_cleared", int'(out_valid), 0);
        chk("simul_busy", int'(busy), 1);
        repeat (8) @(posedge clk);
        #2;

        // Inputs wiggled during RUN are ignored.
        issue(1'b1, 3, 0, 14);
        for (int i = 0; i < 4; i++) begin
            chk("run_in_ready", int'(in_ready), 0);
            chk("run_busy", int'(busy), 1);
            in_a = 4'($urandom_range(0, 15));
            in_op = 1'($urandom_range(0, 1));
            in_valid = ~in_valid;
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;

        // Reset at step 2 of an inverse.
        issue(1'b1, 5, 0, -1);
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        q.delete();
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        #4 rst = 1'b0;
        repeat (8) begin
            @(posedge clk); #2;
            chk("midrst_no_output", int'(out_valid), 0);
        end
        issue(1'b1, 15, 0, 8);
        repeat (8) @(posedge clk);
        #2;

        // Randomized traffic with random consumer backpressure.
        rand_rdy = 1'b1;
        repeat (80) begin
            issue(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15), -1);
            repeat ($urandom_range(0, 3)) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #2;
            end
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
